// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared types and constants.
// Width codes, query types, FSM states, sources.
package mem_ctrl_pkg;

  localparam logic [31:0] IO_BOUNDARY = 32'h0003_0000;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  localparam logic Q_READ  = 1'b0;
  localparam logic Q_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef enum logic {
    SRC_LSB = 1'b0,
    SRC_IF  = 1'b1
  } src_t;

  // Code 3 is not a legal width; it falls back to a word.
  function automatic logic [2:0] byte_count(input logic [1:0] width);
    logic [2:0] n;
    unique case (width)
      WIDTH_BYTE: n = 3'd1;
      WIDTH_HALF: n = 3'd2;
      default:    n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/reply and RAM bus signals of mem_ctrl.
// slave = the controller, master = LSB/IF/RAM side.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);

  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  logic                  lsb_query_en;
  logic                  lsb_query_type;
  logic [ADDR_WIDTH-1:0] lsb_query_addr;
  logic [1:0]            lsb_data_width;
  logic [31:0]           lsb_query_data;
  logic                  lsb_reply_en;
  logic [31:0]           lsb_reply_data;

  logic                  if_query_en;
  logic [ADDR_WIDTH-1:0] if_query_addr;
  logic                  if_reply_en;
  logic [31:0]           if_reply_data;

  modport slave (
    input  mem_din,
    output mem_dout, mem_a, mem_wr,
    input  lsb_query_en, lsb_query_type,
    input  lsb_query_addr, lsb_data_width,
    input  lsb_query_data,
    output lsb_reply_en, lsb_reply_data,
    input  if_query_en, if_query_addr,
    output if_reply_en, if_reply_data
  );

  modport master (
    output mem_din,
    input  mem_dout, mem_a, mem_wr,
    output lsb_query_en, lsb_query_type,
    output lsb_query_addr, lsb_data_width,
    output lsb_query_data,
    input  lsb_reply_en, lsb_reply_data,
    output if_query_en, if_query_addr,
    input  if_reply_en, if_reply_data
  );

endinterface

// File: rtl/mem_ctrl.sv
// LSB/IF arbiter serialising accesses into
// byte-wide transactions on a synchronous RAM bus.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BOUNDARY =
    ADDR_WIDTH'(mem_ctrl_pkg::IO_BOUNDARY)
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       io_buffer_full,
  input  logic       flush_signal,
  mem_ctrl_if.slave  bus
);
  import mem_ctrl_pkg::*;

  state_t                state_q, state_d;
  src_t                  src_q, src_d;
  logic [2:0]            i_q, i_d;
  logic [2:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           buf_q, buf_d;
  logic [7:0]            dout_q, dout_d;
  logic                  wr_q, wr_d;
  logic                  lrep_q, lrep_d;
  logic                  irep_q, irep_d;
  logic [31:0]           ldat_q, ldat_d;
  logic [31:0]           idat_q, idat_d;

  logic [2:0]  i_nx;
  logic [31:0] asm_w;
  logic        io_defer;
  logic        can_acc;
  logic        acc_lsb;
  logic        acc_if;

  assign i_nx = i_q + 3'd1;

  // Byte i-1 arrives on mem_din one cycle after its address.
  assign asm_w = buf_q |
    ({24'h0, bus.mem_din} << {i_q[1:0] - 2'd1, 3'b000});

  assign io_defer = (bus.lsb_query_type == Q_WRITE) &&
                    (bus.lsb_query_addr >= IO_BOUNDARY) &&
                    io_buffer_full;

  // A requester still sees its own pulse this cycle.
  assign can_acc = (state_q == IDLE) && !flush_signal &&
                   !lrep_q && !irep_q;
  assign acc_lsb = can_acc && bus.lsb_query_en && !io_defer;
  assign acc_if  = can_acc && !acc_lsb && bus.if_query_en;

  assign bus.mem_a          = a_q;
  assign bus.mem_dout       = dout_q;
  assign bus.mem_wr         = wr_q;
  assign bus.lsb_reply_en   = lrep_q;
  assign bus.lsb_reply_data = ldat_q;
  assign bus.if_reply_en    = irep_q;
  assign bus.if_reply_data  = idat_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    i_d     = i_q;
    n_d     = n_q;
    addr_d  = addr_q;
    a_d     = a_q;
    data_d  = data_q;
    buf_d   = buf_q;
    dout_d  = dout_q;
    wr_d    = wr_q;
    lrep_d  = lrep_q;
    irep_d  = irep_q;
    ldat_d  = ldat_q;
    idat_d  = idat_q;
    if (rdy_in) begin
      lrep_d = 1'b0;
      irep_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          wr_d  = 1'b0;
          a_d   = '0;
          i_d   = '0;
          buf_d = '0;
          if (acc_lsb) begin
            src_d  = SRC_LSB;
            addr_d = bus.lsb_query_addr;
            data_d = bus.lsb_query_data;
            n_d    = byte_count(bus.lsb_data_width);
            a_d    = bus.lsb_query_addr;
            if (bus.lsb_query_type == Q_WRITE) begin
              state_d = WRITE;
              wr_d    = 1'b1;
              dout_d  = bus.lsb_query_data[7:0];
            end else begin
              state_d = READ;
            end
          end else if (acc_if) begin
            src_d   = SRC_IF;
            addr_d  = bus.if_query_addr;
            n_d     = 3'd4;
            a_d     = bus.if_query_addr;
            state_d = READ;
          end
        end
        READ: begin
          if (flush_signal) begin
            state_d = IDLE;
            a_d     = '0;
          end else if (i_q == n_q) begin
            state_d = IDLE;
            a_d     = '0;
            if (src_q == SRC_LSB) begin
              lrep_d = 1'b1;
              ldat_d = asm_w;
            end else begin
              irep_d = 1'b1;
              idat_d = asm_w;
            end
          end else begin
            i_d = i_nx;
            if (i_q != 3'd0) buf_d = asm_w;
            if (i_nx < n_q)
              a_d = addr_q + ADDR_WIDTH'(i_nx);
            else
              a_d = '0;
          end
        end
        WRITE: begin
          if (!wr_q) begin
            wr_d = 1'b1;
          end else if (i_nx == n_q) begin
            state_d = IDLE;
            wr_d    = 1'b0;
            a_d     = '0;
            dout_d  = '0;
            lrep_d  = 1'b1;
            ldat_d  = '0;
          end else begin
            i_d    = i_nx;
            a_d    = addr_q + ADDR_WIDTH'(i_nx);
            dout_d = 8'(data_q >> {i_nx[1:0], 3'b000});
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      // Stall: drop the strobe, restart reads from byte 0.
      wr_d = 1'b0;
      if (state_q == READ) begin
        i_d   = '0;
        a_d   = addr_q;
        buf_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      src_q   <= SRC_LSB;
      i_q     <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      a_q     <= '0;
      data_q  <= '0;
      buf_q   <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      lrep_q  <= 1'b0;
      irep_q  <= 1'b0;
      ldat_q  <= '0;
      idat_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      i_q     <= i_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      a_q     <= a_d;
      data_q  <= data_d;
      buf_q   <= buf_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      lrep_q  <= lrep_d;
      irep_q  <= irep_d;
      ldat_q  <= ldat_d;
      idat_q  <= idat_d;
    end
  end

endmodule
